// File: rtl/constants_pkg.sv
// constants_pkg: shared widths (PHY_LEN address bits, ICLLEN line bits) and instruction memory defaults
package constants_pkg;
  localparam int PHY_LEN = 20;
  localparam int ICLLEN = 128;
  localparam int IMEM_LATENCY = 5;
  localparam int IMEM_LINES = 1024;
endpackage

// File: rtl/instruction_bus.sv
// instruction_bus: line fetch bus; requester drives ldp/addr, provider returns ldr/ldData
interface instruction_bus;
  import constants_pkg::*;
  logic ldp;
  logic [PHY_LEN-1:0] addr;
  logic ldr;
  logic [ICLLEN-1:0] ldData;
  modport provider(input ldp, addr, output ldr, ldData);
  modport requester(output ldp, addr, input ldr, ldData);
endinterface

// File: rtl/imem_array.sv
// imem_array: LINES x WIDTH storage; clk, sync write (wr_en/wr_line/wr_data), async read (rd_line -> rd_data)
module imem_array #(
  parameter int LINES = 1024,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(LINES)-1:0] wr_line,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(LINES)-1:0] rd_line,
  output logic [WIDTH-1:0]         rd_data
);
  logic [WIDTH-1:0] mem [LINES];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_line] <= wr_data;
  assign rd_data = mem[rd_line];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction memory; clk/rst, ibus provider (ldp,addr -> ldr,ldData), preload write port (wr_en,wr_line,wr_data), busy
module imem_responder
  import constants_pkg::*;
#(
  parameter int MEM_LATENCY = IMEM_LATENCY,
  parameter int MEM_LINES = IMEM_LINES
) (
  input  logic                         clk,
  input  logic                         rst,
  instruction_bus.provider             ibus,
  input  logic                         wr_en,
  input  logic [$clog2(MEM_LINES)-1:0] wr_line,
  input  logic [ICLLEN-1:0]            wr_data,
  output logic                         busy
);
  localparam int IW = $clog2(MEM_LINES);
  localparam int OFF = $clog2(ICLLEN / 8);
  localparam logic [3:0] CNT_INIT = MEM_LATENCY > 1 ? 4'(MEM_LATENCY - 2) : 4'd0;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [IW-1:0] idx_q, idx_n;
  logic [ICLLEN-1:0] rd_data;
  imem_array #(.LINES(MEM_LINES), .WIDTH(ICLLEN)) u_array (
    .clk,
    .wr_en,
    .wr_line,
    .wr_data,
    .rd_line(idx_q),
    .rd_data
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx_q <= idx_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx_q;
    case (state)
      IDLE: if (ibus.ldp) begin
        idx_n = ibus.addr[OFF+IW-1:OFF];
        state_n = MEM_LATENCY == 1 ? RESP : WAIT;
        cnt_n = CNT_INIT;
      end
      WAIT: begin
        state_n = !ibus.ldp ? IDLE : cnt == 4'd0 ? RESP : WAIT;
        cnt_n = ibus.ldp && cnt != 4'd0 ? cnt - 4'd1 : cnt;
      end
      default: state_n = IDLE;
    endcase
  end
  assign ibus.ldr = state == RESP;
  assign ibus.ldData = state == RESP ? rd_data : '0;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks of latency, wrap, abort, reset, back-to-back and write hazards
module tb_imem_responder;
  import constants_pkg::*;
  localparam logic [127:0] L1 = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
  localparam logic [127:0] L2 = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
  localparam logic [127:0] L3 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] L16 = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] ONES = {128{1'b1}};
  logic clk = 1'b0;
  logic rst;
  logic wr_en;
  logic [9:0] wr_line;
  logic [127:0] wr_data;
  logic busy;
  int checks = 0;
  int failures = 0;
  instruction_bus bus();
  imem_responder dut (
    .clk(clk),
    .rst(rst),
    .ibus(bus),
    .wr_en(wr_en),
    .wr_line(wr_line),
    .wr_data(wr_data),
    .busy(busy)
  );
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [9:0] l, input logic [127:0] d);
    wr_en = 1'b1;
    wr_line = l;
    wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.ldp = 1'b1;
    bus.addr = 20'h00034;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({busy, bus.ldr, bus.ldData} !== 130'd0) begin
        failures++;
        $display("FAIL reset i=%0d busy=%b ldr=%b ldData=%h expected all zero", i, busy, bus.ldr, bus.ldData);
      end
    end
    bus.ldp = 1'b0;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    logic [127:0] ed;
    bus.ldp = 1'b1;
    bus.addr = 20'h00034;
    checks++;
    if ({busy, bus.ldr} !== 2'b00) begin
      failures++;
      $display("FAIL basic_accept busy=%b ldr=%b expected 00", busy, bus.ldr);
    end
    for (int i = 1; i <= 6; i++) begin
      tick;
      ed = i == 5 ? L3 : '0;
      checks++;
      if ({busy, bus.ldr, bus.ldData} !== {i <= 5, i == 5, ed}) begin
        failures++;
        $display("FAIL basic i=%0d busy=%b ldr=%b ldData=%h expected busy=%b ldr=%b ldData=%h", i, busy, bus.ldr, bus.ldData, i <= 5, i == 5, ed);
      end
      if (i == 5) bus.ldp = 1'b0;
    end
  endtask

  task automatic test_wrap;
    logic [127:0] ed;
    bus.ldp = 1'b1;
    bus.addr = 20'h04030;
    for (int i = 1; i <= 6; i++) begin
      tick;
      ed = i == 5 ? L3 : '0;
      checks++;
      if ({busy, bus.ldr, bus.ldData} !== {i <= 5, i == 5, ed}) begin
        failures++;
        $display("FAIL wrap i=%0d busy=%b ldr=%b ldData=%h expected busy=%b ldr=%b ldData=%h", i, busy, bus.ldr, bus.ldData, i <= 5, i == 5, ed);
      end
      if (i == 2) bus.addr = 20'h00100;
      if (i == 5) bus.ldp = 1'b0;
    end
  endtask

  task automatic test_abort;
    logic [127:0] ed;
    logic eb;
    bus.ldp = 1'b1;
    bus.addr = 20'h00034;
    for (int i = 1; i <= 10; i++) begin
      tick;
      eb = i <= 3 || (i >= 5 && i <= 9);
      ed = i == 9 ? L3 : '0;
      checks++;
      if ({busy, bus.ldr, bus.ldData} !== {eb, i == 9, ed}) begin
        failures++;
        $display("FAIL abort i=%0d busy=%b ldr=%b ldData=%h expected busy=%b ldr=%b ldData=%h", i, busy, bus.ldr, bus.ldData, eb, i == 9, ed);
      end
      if (i == 3) bus.ldp = 1'b0;
      if (i == 4) bus.ldp = 1'b1;
      if (i == 9) bus.ldp = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    bus.ldp = 1'b1;
    bus.addr = 20'h00034;
    for (int i = 1; i <= 3; i++) begin
      tick;
      checks++;
      if ({busy, bus.ldr} !== 2'b10) begin
        failures++;
        $display("FAIL rstmid_wait i=%0d busy=%b ldr=%b expected busy=1 ldr=0", i, busy, bus.ldr);
      end
    end
    rst = 1'b1;
    bus.ldp = 1'b0;
    #1;
    checks++;
    if ({busy, bus.ldr, bus.ldData} !== 130'd0) begin
      failures++;
      $display("FAIL rstmid_async busy=%b ldr=%b ldData=%h expected all zero", busy, bus.ldr, bus.ldData);
    end
    rst = 1'b0;
    for (int i = 4; i <= 6; i++) begin
      tick;
      checks++;
      if ({busy, bus.ldr, bus.ldData} !== 130'd0) begin
        failures++;
        $display("FAIL rstmid_after i=%0d busy=%b ldr=%b ldData=%h expected all zero", i, busy, bus.ldr, bus.ldData);
      end
    end
    test_basic;
  endtask

  task automatic test_back_to_back;
    logic [127:0] ed;
    logic eb;
    logic er;
    bus.ldp = 1'b1;
    bus.addr = 20'h00010;
    for (int i = 1; i <= 12; i++) begin
      tick;
      eb = i != 6 && i != 12;
      er = i == 5 || i == 11;
      ed = i == 5 ? L1 : i == 11 ? L2 : '0;
      checks++;
      if ({busy, bus.ldr, bus.ldData} !== {eb, er, ed}) begin
        failures++;
        $display("FAIL b2b i=%0d busy=%b ldr=%b ldData=%h expected busy=%b ldr=%b ldData=%h", i, busy, bus.ldr, bus.ldData, eb, er, ed);
      end
      if (i == 5) bus.addr = 20'h00020;
      if (i == 11) bus.ldp = 1'b0;
    end
  endtask

  task automatic test_write_hazard;
    logic [127:0] ed;
    bus.ldp = 1'b1;
    bus.addr = 20'h00034;
    for (int i = 1; i <= 6; i++) begin
      tick;
      wr_en = 1'b0;
      ed = i == 5 ? ONES : '0;
      checks++;
      if ({busy, bus.ldr, bus.ldData} !== {i <= 5, i == 5, ed}) begin
        failures++;
        $display("FAIL wr_wait i=%0d busy=%b ldr=%b ldData=%h expected busy=%b ldr=%b ldData=%h", i, busy, bus.ldr, bus.ldData, i <= 5, i == 5, ed);
      end
      if (i == 2) begin
        wr_en = 1'b1;
        wr_line = 10'd3;
        wr_data = ONES;
      end
      if (i == 5) bus.ldp = 1'b0;
    end
    bus.ldp = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick;
      wr_en = 1'b0;
      if (i == 5) begin
        wr_en = 1'b1;
        wr_line = 10'd3;
        wr_data = L3;
        bus.ldp = 1'b0;
        #1;
      end
      ed = i == 5 ? ONES : '0;
      checks++;
      if ({busy, bus.ldr, bus.ldData} !== {i <= 5, i == 5, ed}) begin
        failures++;
        $display("FAIL wr_resp i=%0d busy=%b ldr=%b ldData=%h expected busy=%b ldr=%b ldData=%h", i, busy, bus.ldr, bus.ldData, i <= 5, i == 5, ed);
      end
    end
    test_basic;
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    wr_line = '0;
    wr_data = '0;
    bus.ldp = 1'b0;
    bus.addr = '0;
    test_reset;
    preload(10'd1, L1);
    preload(10'd2, L2);
    preload(10'd3, L3);
    preload(10'd16, L16);
    test_basic;
    test_wrap;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    test_write_hazard;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter MEM_LATENCY, default IMEM_LATENCY (5): cycles from request acceptance to response; legal range 1..15.
REQ-002 Parameter MEM_LINES, default IMEM_LINES (1024): number of ICLLEN-bit lines stored; power of two.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ibus  instruction_bus.provider  --  provider end of the instruction bus: ldp in (1), addr in (PHY_LEN), ldr out (1), ldData out (ICLLEN).
REQ-006 wr_en  input  1  preload/backdoor write strobe.
REQ-007 wr_line  input  $clog2(MEM_LINES)  line index for the preload write.
REQ-008 wr_data  input  ICLLEN  line data for the preload write.
REQ-009 busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 The block SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-011 IDLE: ldp=1 SHALL latch line index idx_q = addr[OFF+$clog2(MEM_LINES)-1:OFF], where OFF=$clog2(ICLLEN/8); byte-offset bits and bits above the index are ignored, so addresses wrap modulo MEM_LINES.
REQ-012 IDLE with ldp=1: if MEM_LATENCY=1, go to RESP; otherwise go to WAIT with down-counter cnt=MEM_LATENCY-2.
REQ-013 WAIT: ldp=0 SHALL abort (go to IDLE, no ldr); else cnt=0 -> RESP, else cnt decrements.
REQ-014 RESP: ldr=1 for exactly one cycle with ldData=mem[idx_q]; next state is always IDLE.
REQ-015 If ldp is first high in cycle k while in IDLE and stays high, ldr SHALL be high in cycle k+MEM_LATENCY and no other cycle.
REQ-016 ldr and ldData SHALL be Moore outputs (function of state and idx_q only); ldData SHALL be all-zero whenever ldr=0.
REQ-017 addr changes after acceptance SHALL be ignored until the next IDLE acceptance.
REQ-018 ldp still high in the cycle after RESP (IDLE) SHALL be treated as a new request; back-to-back accepts SHALL leave no dead cycle.
REQ-019 wr_en=1 SHALL write wr_data to mem[wr_line] at the rising edge in any state.
REQ-020 Write in the RESP cycle to idx_q: ldData SHALL return the old line; the new value is visible from the next cycle.
REQ-021 Write during WAIT to idx_q: the subsequent response SHALL return the new line.

Reset
REQ-022 rst=1 SHALL immediately force state=IDLE, cnt=0, idx_q=0, ldr=0, ldData=0, busy=0.
REQ-023 Reset mid-transaction (WAIT or RESP) SHALL drop the request with no ldr pulse after reset deasserts unless ldp is resampled in IDLE.
REQ-024 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-025 IMEM_LATENCY and IMEM_LINES SHALL be added to constants_pkg beside PHY_LEN and ICLLEN; the state enum is local.
REQ-026 Storage SHALL be a sub-module imem_array (MEM_LINES x ICLLEN, synchronous write port, asynchronous read port); FSM and counter stay in imem_responder.

Verification (ICLLEN=128, MEM_LATENCY=5, MEM_LINES=1024)
REQ-027 Preload line 3 = 0x0123_4567_89AB_CDEF_0011_2233_4455_6677; ldp=1, addr=0x00034 from cycle 10 -> ldr only in cycle 15 with that data; busy in cycles 11-15.
REQ-028 addr=0x04030 (wraps to line 3) -> same data returned; addr changed to 0x00100 in cycle 12 -> still line 3.
REQ-029 ldp dropped in cycle 13 -> no ldr, IDLE in cycle 14; new request in cycle 14 -> ldr in cycle 19.
REQ-030 rst pulsed in cycle 13 of a request -> ldr=0, busy=0 immediately; no ldr in cycle 15; line 3 still readable afterwards.
REQ-031 ldp held high through two requests to lines 1 and 2 (accepted cycles 10 and 16) -> ldr in cycles 15 and 21 with correct lines.
REQ-032 Write line 3 = all-ones in cycle 12 (WAIT) -> ldData all-ones in cycle 15; write in cycle 15 (RESP) -> old data in cycle 15.
